// File: rtl/arf_pkg.sv
// Shared definitions for the ARF frame controller.
//   ARF_NSAMP / ARF_W : samples per frame and default data word width.
//   arf_state_e       : controller FSM states (LOAD, RUN, OUT).
//   arf_abs_diff_sat  : |a - b| of two signed words. The difference is taken
//                       at ARF_W+1 bits and the magnitude is saturated to ARF_W bits.
package arf_pkg;

    localparam int ARF_NSAMP = 8;
    localparam int ARF_W     = 32;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } arf_state_e;

    function automatic logic [ARF_W-1:0] arf_abs_diff_sat(input logic [ARF_W-1:0] a,
                                                          input logic [ARF_W-1:0] b);
        logic [ARF_W:0] diff;
        logic [ARF_W:0] mag;
        // Sign-extend both operands so the subtraction cannot overflow.
        diff = {a[ARF_W-1], a} - {b[ARF_W-1], b};
        mag  = diff[ARF_W] ? (~diff + 1'b1) : diff;
        return mag[ARF_W] ? {ARF_W{1'b1}} : mag[ARF_W-1:0];
    endfunction

endpackage

// File: rtl/arf_frame_ctrl_if.sv
// Stream interface of the ARF frame controller.
//   s_valid/s_ready/s_data        : sample input stream.
//   m_valid/m_ready/m_out27/28    : result output stream.
// Modports:
//   master : the environment, which drives samples and accepts results.
//   slave  : the controller.
import arf_pkg::*;

interface arf_frame_ctrl_if #(
    parameter int W = ARF_W
);
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_out27;
    logic [W-1:0] m_out28;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_out27, m_out28
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_out27, m_out28
    );
endinterface

// File: rtl/arf_err_stat.sv
// Error statistics between a datapath and a reference datapath run in lockstep.
// Built only when ARF_ERR_STAT_EN is defined.
//   clk, rst_n         : clock and asynchronous active-low reset.
//   clr_i              : synchronous clear of all statistics. It wins over cap_i.
//   cap_i              : capture strobe, one cycle per frame.
//   out27_i/out28_i    : datapath outputs.
//   ref27_i/ref28_i    : reference datapath outputs.
//   err_acc_o          : saturating sum of absolute errors.
//   err_max_o          : largest single absolute error.
//   frame_cnt_o        : number of captured frames. It wraps at 2^16.
import arf_pkg::*;

module arf_err_stat (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    input  logic               cap_i,
    input  logic [ARF_W-1:0]   out27_i,
    input  logic [ARF_W-1:0]   out28_i,
    input  logic [ARF_W-1:0]   ref27_i,
    input  logic [ARF_W-1:0]   ref28_i,
    output logic [ARF_W+7:0]   err_acc_o,
    output logic [ARF_W-1:0]   err_max_o,
    output logic [15:0]        frame_cnt_o
);
    logic [ARF_W+7:0] acc_q, acc_d;
    logic [ARF_W-1:0] max_q, max_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [ARF_W-1:0] d27, d28, dmax;
    logic [ARF_W+8:0] sum;

    always_comb begin
        d27   = arf_abs_diff_sat(out27_i, ref27_i);
        d28   = arf_abs_diff_sat(out28_i, ref28_i);
        dmax  = (d27 > d28) ? d27 : d28;
        // The extra top bit catches overflow so the sum can saturate.
        sum   = {1'b0, acc_q} + {9'd0, d27} + {9'd0, d28};
        acc_d = acc_q;
        max_d = max_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            acc_d = '0;
            max_d = '0;
            cnt_d = '0;
        end else if (cap_i) begin
            acc_d = sum[ARF_W+8] ? {(ARF_W+8){1'b1}} : sum[ARF_W+7:0];
            max_d = (dmax > max_q) ? dmax : max_q;
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            max_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            max_q <= max_d;
            cnt_q <= cnt_d;
        end
    end

    assign err_acc_o   = acc_q;
    assign err_max_o   = max_q;
    assign frame_cnt_o = cnt_q;
endmodule

// File: rtl/arf_frame_ctrl.sv
// ARF frame controller.
// The controller collects NSAMP samples and drives them onto the datapath
// together with the fed-back state. It waits LATENCY cycles, then captures
// outputs 27 and 28 and offers them downstream. On the result handshake,
// those outputs become the state inputs 13 and 14 for the next frame.
// Ports:
//   clk, rst_n         : clock and asynchronous active-low reset.
//   sif (slave)        : sample stream in and result stream out.
//   clr_state          : pulse that zeroes the feedback state. If it arrives
//                        mid-frame, it is deferred to the result handshake.
//   dp_in              : samples to the datapath. Word k is at [k*W +: W].
//   dp_st13/dp_st14    : state inputs in_13_1 and in_14_1.
//   dp_out27/dp_out28  : datapath outputs.
//   busy               : high outside LOAD.
// Optional: define ARF_ERR_STAT_EN to add error statistics against a
// reference datapath. This adds ports ref_out27, ref_out28, err_acc,
// err_max and frame_cnt.
import arf_pkg::*;

module arf_frame_ctrl #(
    parameter int W       = ARF_W,
    parameter int NSAMP   = ARF_NSAMP,
    parameter int LATENCY = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    arf_frame_ctrl_if.slave     sif,
    input  logic                clr_state,
    output logic [NSAMP*W-1:0]  dp_in,
    output logic [W-1:0]        dp_st13,
    output logic [W-1:0]        dp_st14,
    input  logic [W-1:0]        dp_out27,
    input  logic [W-1:0]        dp_out28,
    output logic                busy
`ifdef ARF_ERR_STAT_EN
    ,
    input  logic [W-1:0]        ref_out27,
    input  logic [W-1:0]        ref_out28,
    output logic [W+7:0]        err_acc,
    output logic [W-1:0]        err_max,
    output logic [15:0]         frame_cnt
`endif
);
    localparam int         CW        = $clog2(NSAMP);
    localparam logic [CW-1:0] LAST   = CW'(NSAMP - 1);
    localparam logic [7:0] WAIT_INIT = 8'(LATENCY - 1);

    arf_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    wait_q, wait_d;
    logic [W-1:0]  st13_q, st13_d, st14_q, st14_d;
    logic          m_valid_q, m_valid_d;
    logic [W-1:0]  m_out27_q, m_out27_d, m_out28_q, m_out28_d;
    logic          clr_pend_q, clr_pend_d;
    logic          cap;
    logic          load_hs;

    assign load_hs = (state_q == LOAD) && sif.s_valid;

    // One register per sample slot. A slot is written only by the handshake
    // that addresses it, so it stays stable through RUN and OUT.
    for (genvar gi = 0; gi < NSAMP; gi++) begin : g_slot
        logic [W-1:0] slot_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                slot_q <= '0;
            else if (load_hs && (cnt_q == CW'(gi)))
                slot_q <= sif.s_data;
        end
        assign dp_in[gi*W +: W] = slot_q;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wait_d     = wait_q;
        st13_d     = st13_q;
        st14_d     = st14_q;
        m_valid_d  = m_valid_q;
        m_out27_d  = m_out27_q;
        m_out28_d  = m_out28_q;
        clr_pend_d = clr_pend_q;
        cap        = 1'b0;
        case (state_q)
            LOAD: begin
                if (clr_state) begin
                    st13_d = '0;
                    st14_d = '0;
                end
                if (sif.s_valid) begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        wait_d  = WAIT_INIT;
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RUN: begin
                if (clr_state) clr_pend_d = 1'b1;
                if (wait_q == 8'd0) begin
                    cap       = 1'b1;
                    m_out27_d = dp_out27;
                    m_out28_d = dp_out28;
                    m_valid_d = 1'b1;
                    state_d   = OUT;
                end else begin
                    wait_d = wait_q - 8'd1;
                end
            end
            OUT: begin
                if (clr_state) clr_pend_d = 1'b1;
                if (sif.m_ready) begin
                    m_valid_d  = 1'b0;
                    clr_pend_d = 1'b0;
                    state_d    = LOAD;
                    // A clear that arrives on the handshake cycle itself also
                    // wins over the feedback.
                    if (clr_pend_q || clr_state) begin
                        st13_d = '0;
                        st14_d = '0;
                    end else begin
                        st13_d = m_out27_q;
                        st14_d = m_out28_q;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOAD;
            cnt_q      <= '0;
            wait_q     <= '0;
            st13_q     <= '0;
            st14_q     <= '0;
            m_valid_q  <= 1'b0;
            m_out27_q  <= '0;
            m_out28_q  <= '0;
            clr_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wait_q     <= wait_d;
            st13_q     <= st13_d;
            st14_q     <= st14_d;
            m_valid_q  <= m_valid_d;
            m_out27_q  <= m_out27_d;
            m_out28_q  <= m_out28_d;
            clr_pend_q <= clr_pend_d;
        end
    end

    assign sif.s_ready = (state_q == LOAD);
    assign sif.m_valid = m_valid_q;
    assign sif.m_out27 = m_out27_q;
    assign sif.m_out28 = m_out28_q;
    assign dp_st13     = st13_q;
    assign dp_st14     = st14_q;
    assign busy        = (state_q != LOAD);

`ifdef ARF_ERR_STAT_EN
    arf_err_stat u_err_stat (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (clr_state),
        .cap_i       (cap),
        .out27_i     (dp_out27),
        .out28_i     (dp_out28),
        .ref27_i     (ref_out27),
        .ref28_i     (ref_out28),
        .err_acc_o   (err_acc),
        .err_max_o   (err_max),
        .frame_cnt_o (frame_cnt)
    );
`endif
endmodule

// File: tb/tb_arf_frame_ctrl.sv
// Directed testbench for arf_frame_ctrl.
// A stub datapath computes out27 = sum(samples) + st13 and
// out28 = sample7 - st14. Expected results are pushed to a scoreboard
// queue when a frame is sent. They are popped and compared on capture.
// Statistics checks are active when ARF_ERR_STAT_EN is defined.
`timescale 1ns/1ps
import arf_pkg::*;

module tb_arf_frame_ctrl;
    localparam int W   = 32;
    localparam int NS  = 8;
    localparam int LAT = 4;

    typedef struct packed {
        logic [W-1:0] o27;
        logic [W-1:0] o28;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr_state = 1'b0;
    logic [NS*W-1:0] dp_in;
    logic [W-1:0] dp_st13, dp_st14, dp_out27, dp_out28;
    logic busy;
`ifdef ARF_ERR_STAT_EN
    logic [W-1:0] ref_out27, ref_out28;
    logic [W+7:0] err_acc;
    logic [W-1:0] err_max;
    logic [15:0]  frame_cnt;
`endif

    arf_frame_ctrl_if #(.W(W)) sif ();

    arf_frame_ctrl #(.W(W), .NSAMP(NS), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sif       (sif.slave),
        .clr_state (clr_state),
        .dp_in     (dp_in),
        .dp_st13   (dp_st13),
        .dp_st14   (dp_st14),
        .dp_out27  (dp_out27),
        .dp_out28  (dp_out28),
        .busy      (busy)
`ifdef ARF_ERR_STAT_EN
        ,
        .ref_out27 (ref_out27),
        .ref_out28 (ref_out28),
        .err_acc   (err_acc),
        .err_max   (err_max),
        .frame_cnt (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Stub datapath
    always_comb begin
        dp_out27 = dp_st13;
        for (int k = 0; k < NS; k++) dp_out27 = dp_out27 + dp_in[k*W +: W];
    end
    assign dp_out28 = dp_in[7*W +: W] - dp_st14;
`ifdef ARF_ERR_STAT_EN
    assign ref_out27 = dp_out27 + 32'd3;
    assign ref_out28 = dp_out28 - 32'd5;
`endif

    int   checks = 0;
    int   errors = 0;
    res_t sb_q[$];
    res_t last_res;
    logic [W-1:0] st13_m = '0;
    logic [W-1:0] st14_m = '0;
    logic [W-1:0] frame_w [NS];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] d);
        int n;
        n = 0;
        sif.s_valid = 1'b1;
        sif.s_data  = d;
        while (sif.s_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("s_ready_timeout", 64'(n >= 50), 64'd0);
        tick();
        sif.s_valid = 1'b0;
    endtask

    // Sends frame_w, then checks the RUN window and the capture.
    task automatic send_frame(input bit clr_mid);
        res_t e;
        res_t got;
        e.o27 = st13_m;
        for (int k = 0; k < NS; k++) e.o27 = e.o27 + frame_w[k];
        e.o28 = frame_w[7] - st14_m;
        sb_q.push_back(e);
        for (int k = 0; k < NS; k++) send_word(frame_w[k]);
        for (int k = 1; k <= LAT; k++) begin
            if (clr_mid && k == 2) clr_state = 1'b1;
            tick();
            clr_state = 1'b0;
            if (k < LAT) begin
                chk("m_valid_early", 64'(sif.m_valid), 64'd0);
                chk("busy_run", 64'(busy), 64'd1);
                chk("st13_run", 64'(dp_st13), 64'(st13_m));
                chk("st14_run", 64'(dp_st14), 64'(st14_m));
            end else begin
                chk("m_valid_cap", 64'(sif.m_valid), 64'd1);
                chk("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
                if (sb_q.size() > 0) begin
                    got = sb_q.pop_front();
                    last_res = got;
                    chk("m_out27", 64'(sif.m_out27), 64'(got.o27));
                    chk("m_out28", 64'(sif.m_out28), 64'(got.o28));
                    $display("frame: out27=%0h out28=%0h exp27=%0h exp28=%0h",
                             sif.m_out27, sif.m_out28, got.o27, got.o28);
                end
            end
        end
    endtask

    // Holds off the result for `hold` cycles, then accepts it.
    task automatic receive(input int hold, input bit pend);
        sif.s_valid = (hold > 0);
        sif.s_data  = 32'hDEAD_BEEF;
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("bp_s_ready", 64'(sif.s_ready), 64'd0);
            chk("bp_m_valid", 64'(sif.m_valid), 64'd1);
            chk("bp_out27", 64'(sif.m_out27), 64'(last_res.o27));
            chk("bp_out28", 64'(sif.m_out28), 64'(last_res.o28));
        end
        sif.m_ready = 1'b1;
        tick();
        sif.m_ready = 1'b0;
        sif.s_valid = 1'b0;
        if (pend) begin
            st13_m = '0;
            st14_m = '0;
        end else begin
            st13_m = last_res.o27;
            st14_m = last_res.o28;
        end
        chk("hs_m_valid", 64'(sif.m_valid), 64'd0);
        chk("hs_busy", 64'(busy), 64'd0);
        chk("hs_s_ready", 64'(sif.s_ready), 64'd1);
        chk("hs_st13", 64'(dp_st13), 64'(st13_m));
        chk("hs_st14", 64'(dp_st14), 64'(st14_m));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_dp_in"}, 64'(dp_in == '0), 64'd1);
        chk({tag, "_st13"}, 64'(dp_st13), 64'd0);
        chk({tag, "_st14"}, 64'(dp_st14), 64'd0);
        chk({tag, "_m_valid"}, 64'(sif.m_valid), 64'd0);
        chk({tag, "_m_out27"}, 64'(sif.m_out27), 64'd0);
        chk({tag, "_m_out28"}, 64'(sif.m_out28), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
`ifdef ARF_ERR_STAT_EN
        chk({tag, "_err_acc"}, 64'(err_acc), 64'd0);
        chk({tag, "_frame_cnt"}, 64'(frame_cnt), 64'd0);
`endif
    endtask

    initial begin
        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        sif.m_ready = 1'b0;
        last_res    = '0;

        // Reset
        #12;
        check_zero("rst");
        rst_n = 1'b1;
        tick();
        chk("rst_s_ready", 64'(sif.s_ready), 64'd1);

        // Basic frame (1..8), with m_ready asserted early and backpressure
        sif.m_ready = 1'b1;
        tick();
        sif.m_ready = 1'b0;
        chk("early_m_ready", 64'(sif.m_valid), 64'd0);
        for (int k = 0; k < NS; k++) frame_w[k] = W'(k + 1);
        send_frame(1'b0);
        chk("f1_out27_const", 64'(sif.m_out27), 64'd36);
        receive(10, 1'b0);

        // Feedback frame of all ones, with a clear during RUN
        for (int k = 0; k < NS; k++) frame_w[k] = 32'd1;
        send_frame(1'b1);
        chk("f2_out28_const", 64'(sif.m_out28), 64'hFFFF_FFF9);
        receive(0, 1'b1);

        // Third frame must start from zero state
        for (int k = 0; k < NS; k++) frame_w[k] = W'(k + 2);
        send_frame(1'b0);
        receive(2, 1'b0);

        // Async reset after five samples
        for (int k = 0; k < 5; k++) send_word(W'(100 + k));
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        #2;
        rst_n = 1'b1;
        st13_m = '0;
        st14_m = '0;
        tick();
        for (int k = 0; k < NS; k++) frame_w[k] = W'(k + 10);
        send_frame(1'b0);
        receive(0, 1'b0);

        // Clear in LOAD, then four frames for statistics
        clr_state = 1'b1;
        tick();
        clr_state = 1'b0;
        st13_m = '0;
        st14_m = '0;
        chk("clr_load_st13", 64'(dp_st13), 64'd0);
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < NS; k++) frame_w[k] = W'(f * 8 + k + 3);
            send_frame(1'b0);
            receive(1, 1'b0);
        end
`ifdef ARF_ERR_STAT_EN
        chk("err_acc", 64'(err_acc), 64'd32);
        chk("err_max", 64'(err_max), 64'd5);
        chk("frame_cnt", 64'(frame_cnt), 64'd4);
`endif
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
